pc_fetch_unit: RTL

//  Holds the architectural PC and fetches one instruction at a time from the instruction SRAM-like port.

---
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC and fetches one instruction at a time.
// Ports: clk/rst; next_pc, flush/flush_pc in; inst_* memory port; inst_valid/id_ready,
// pc_out, inst_out, fetch_err, fetch_cnt toward decode.
module pc_fetch_unit #(
  parameter int             n        = 32,
  parameter logic [n-1:0]   RESET_PC = 32'hBFC00000,
  parameter logic [n-1:0]   NOP_INST = 32'h00000000,
  // reset value of fetch_cnt
  parameter logic [31:0]    CNT_INIT = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] next_pc,
  input  logic         flush,
  input  logic [n-1:0] flush_pc,
  output logic         inst_req,
  output logic [n-1:0] inst_addr,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [n-1:0] inst_rdata,
  output logic         inst_valid,
  input  logic         id_ready,
  output logic [n-1:0] pc_out,
  output logic [n-1:0] inst_out,
  output logic         fetch_err,
  output logic [31:0]  fetch_cnt
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_ERR,
    S_DROP
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] fetch_pc_q, fetch_pc_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] inst_q, inst_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         pending;

  // A read is still in flight after this edge. DROP is included so a
  // flush there cannot launch a second request before the first returns.
  assign pending =
    !inst_data_ok &&
    ((state_q == S_WAIT) ||
     (state_q == S_DROP) ||
     (state_q == S_REQ && inst_addr_ok));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
      state_d    = pending ? S_DROP : S_REQ;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (inst_addr_ok && inst_data_ok) begin
            pc_d    = fetch_pc_q;
            inst_d  = inst_rdata;
            state_d = S_FULL;
          end else if (inst_addr_ok) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            pc_d    = fetch_pc_q;
            inst_d  = inst_rdata;
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          if (id_ready) begin
            cnt_d      = cnt_q + 32'd1;
            fetch_pc_d = next_pc;
            if (next_pc[1:0] == 2'b00) begin
              state_d = S_REQ;
            end else begin
              // misaligned target: park in ERR, never touch memory
              pc_d    = next_pc;
              inst_d  = NOP_INST;
              state_d = S_ERR;
            end
          end
        end
        S_ERR: ;
        S_DROP: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      cnt_q      <= CNT_INIT;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
    end
  end

  assign inst_req   = (state_q == S_REQ);
  assign inst_addr  = fetch_pc_q;
  assign inst_valid = (state_q == S_FULL) ||
                      (state_q == S_ERR);
  assign fetch_err  = (state_q == S_ERR);
  assign pc_out     = pc_q;
  assign inst_out   = inst_q;
  assign fetch_cnt  = cnt_q;

endmodule
